// File: rtl/misao_mem_responder.sv
// misao_mem_responder
// Memory-side responder for the MISA-O byte-wide memory bus: a 2^ADDR_BITS-byte
// RAM plus a 4-byte I/O window (console FIFO data/status, error counter).
// Reads are combinational. Writes commit on the rising clock edge.
// Optional feature: define MISAO_MEM_CONSOLE_EN to build the console FIFO.
// Without it, con_valid/con_data stay 0, CON_STAT reads 0x01 and CON_DATA
// writes are discarded.
module misao_mem_responder #(
    parameter int          ADDR_BITS  = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [14:0] IO_BASE    = 15'h7FF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_enable_read,
    input  logic        mem_enable_write,
    input  logic [14:0] mem_addr,
    input  logic        mem_rw,
    input  logic [7:0]  mem_data_out,
    output logic [7:0]  mem_data_in,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic [7:0]  err_count
);

    localparam int RAM_SIZE = 1 << ADDR_BITS;

    // I/O register offsets inside the window
    localparam logic [1:0] OFF_CON_DATA = 2'd0;
    localparam logic [1:0] OFF_CON_STAT = 2'd1;
    localparam logic [1:0] OFF_ERR_CNT  = 2'd2;

    // NOTE: RAM storage has no reset; clearing a memory array on reset costs a
    // write port per word and the contents are loaded by the environment anyway.
    logic [7:0] r_mem [RAM_SIZE];
    logic [7:0] r_err;

    logic                 w_is_ram;
    logic                 w_is_io;
    logic                 w_unmapped;
    logic [14:0]          w_io_diff;
    logic [1:0]           w_io_off;
    logic [ADDR_BITS-1:0] w_ram_idx;
    logic                 w_wr_ram;
    logic                 w_wr_con;
    logic                 w_wr_stat;
    logic                 w_wr_err;
    logic [7:0]           w_stat;
    logic [7:0]           w_rdata;

    // Address decode: RAM takes priority should the I/O window ever overlap it
    assign w_is_ram   = 32'(mem_addr) < 32'(RAM_SIZE);
    assign w_is_io    = !w_is_ram && (mem_addr >= IO_BASE)
                        && (16'(mem_addr) <= 16'(IO_BASE) + 16'd3);
    assign w_unmapped = !w_is_ram && !w_is_io;
    assign w_io_diff  = mem_addr - IO_BASE;
    assign w_io_off   = w_io_diff[1:0];
    assign w_ram_idx  = mem_addr[ADDR_BITS-1:0];

    assign w_wr_ram  = mem_enable_write && w_is_ram;
    assign w_wr_con  = mem_enable_write && w_is_io && (w_io_off == OFF_CON_DATA);
    assign w_wr_stat = mem_enable_write && w_is_io && (w_io_off == OFF_CON_STAT);
    assign w_wr_err  = mem_enable_write && w_is_io && (w_io_off == OFF_ERR_CNT);

    // RAM write port
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples the pre-edge values, independent of statement order.
        if (w_wr_ram) begin
            r_mem[w_ram_idx] <= mem_data_out;
        end
    end

    // Unmapped-access counter: counts strobed cycles, saturates, cleared by a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 8'h00;
        end else if (w_wr_err) begin
            r_err <= 8'h00;
        end else if ((mem_enable_read || mem_enable_write) && w_unmapped
                     && (r_err != 8'hFF)) begin
            r_err <= r_err + 8'd1;
        end
    end

    assign err_count = r_err;

`ifdef MISAO_MEM_CONSOLE_EN
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [4:0]       r_count;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == 5'd0);
    assign w_full  = (r_count == 5'(FIFO_DEPTH));
    assign w_pop   = !w_empty && con_ready;
    // A same-cycle pop frees the slot the push needs
    assign w_push  = w_wr_con && (!w_full || w_pop);

    // FIFO storage write port (contents are meaningless while empty)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= mem_data_out;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= 5'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 5'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 5'd1;
            end
            if (w_wr_stat) begin
                r_overflow <= 1'b0;
            end else if (w_wr_con && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_stat    = {r_count, r_overflow, w_full, w_empty};
    assign con_valid = !w_empty;
    assign con_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, mem_rw, w_io_diff[14:2]};
`else
    assign w_stat    = 8'h01;
    assign con_valid = 1'b0;
    assign con_data  = 8'h00;

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, mem_rw, w_io_diff[14:2], con_ready,
                           w_wr_con, w_wr_stat};
`endif

    // Combinational read mux: 0x00 without a read strobe or on unmapped/reserved addresses
    always_comb begin
        // NOTE: default first so every path assigns w_rdata and no latch is inferred.
        w_rdata = 8'h00;
        if (mem_enable_read) begin
            if (w_is_ram) begin
                w_rdata = r_mem[w_ram_idx];
            end else if (w_is_io) begin
                case (w_io_off)
                    OFF_CON_STAT: w_rdata = w_stat;
                    OFF_ERR_CNT:  w_rdata = r_err;
                    default:      w_rdata = 8'h00;
                endcase
            end
        end
    end

    assign mem_data_in = w_rdata;

endmodule

// File: tb/tb_misao_mem_responder.sv
// Self-checking bench for misao_mem_responder: directed test-plan cases plus
// randomized traffic compared against a queue/array reference model.
// The console expectations follow MISAO_MEM_CONSOLE_EN as seen by this bench.
module tb_misao_mem_responder;

    localparam int          RAM_SIZE = 256;
    localparam int          DEPTH    = 4;
    localparam logic [14:0] IO       = 15'h7FF0;
`ifdef MISAO_MEM_CONSOLE_EN
    localparam bit CON_EN = 1'b1;
`else
    localparam bit CON_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        rd    = 1'b0;
    logic        wr    = 1'b0;
    logic        rw    = 1'b0;
    logic        rdy   = 1'b0;
    logic [14:0] addr  = 15'd0;
    logic [7:0]  wdata = 8'd0;
    logic [7:0]  rdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic [7:0]  err_count;

    misao_mem_responder #(.ADDR_BITS(8), .FIFO_DEPTH(DEPTH), .IO_BASE(IO)) dut (
        .clk(clk), .rst(rst),
        .mem_enable_read(rd), .mem_enable_write(wr),
        .mem_addr(addr), .mem_rw(rw), .mem_data_out(wdata),
        .mem_data_in(rdata),
        .con_valid(con_valid), .con_data(con_data), .con_ready(rdy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_ram [RAM_SIZE];
    logic [7:0] m_q [$];
    int         m_err = 0;
    bit         m_ovf = 1'b0;

    // Values observed just before the most recent edge
    logic [7:0] obs_rd;
    logic [7:0] obs_cd;
    logic [7:0] obs_err;
    logic       obs_cv;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_is_ram(input logic [14:0] a);
        return int'(a) < RAM_SIZE;
    endfunction

    function automatic bit m_is_io(input logic [14:0] a);
        return (a >= IO) && (a <= IO + 15'd3);
    endfunction

    function automatic logic [7:0] m_stat();
        if (!CON_EN) return 8'h01;
        return {5'(m_q.size()), m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
    endfunction

    function automatic logic [7:0] m_read(input logic r, input logic [14:0] a);
        logic [14:0] off;
        if (!r) return 8'h00;
        if (m_is_ram(a)) return m_ram[a[7:0]];
        if (!m_is_io(a)) return 8'h00;
        off = a - IO;
        case (off[1:0])
            2'd1:    return m_stat();
            2'd2:    return 8'(m_err);
            default: return 8'h00;
        endcase
    endfunction

    // Apply one clock edge worth of behaviour to the model
    task automatic m_update(input logic r, input logic w, input logic [14:0] a,
                            input logic [7:0] d, input logic ry);
        int          sz;
        bit          pop;
        logic [14:0] off;
        sz  = m_q.size();
        pop = CON_EN && (sz != 0) && ry;
        off = a - IO;
        if ((r || w) && !m_is_ram(a) && !m_is_io(a) && m_err < 255) m_err++;
        if (pop) void'(m_q.pop_front());
        if (w && m_is_ram(a)) m_ram[a[7:0]] = d;
        if (w && m_is_io(a)) begin
            case (off[1:0])
                2'd0: if (CON_EN) begin
                    if (sz < DEPTH || pop) m_q.push_back(d);
                    else m_ovf = 1'b1;
                end
                2'd1: m_ovf = 1'b0;
                2'd2: m_err = 0;
                default: ;
            endcase
        end
    endtask

    // Drive one cycle: inputs at the falling edge, compare before the rising edge
    task automatic step(input logic i_rd, input logic i_wr, input logic [14:0] i_a,
                        input logic [7:0] i_d, input logic i_rdy);
        @(negedge clk);
        rd = i_rd; wr = i_wr; addr = i_a; wdata = i_d; rdy = i_rdy;
        #1;
        obs_rd = rdata; obs_cv = con_valid; obs_cd = con_data; obs_err = err_count;
        check("rdata", rdata, m_read(i_rd, i_a));
        check("con_valid", {7'd0, con_valid}, {7'd0, m_q.size() != 0});
        check("con_data", con_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
        check("err_count", err_count, 8'(m_err));
        @(posedge clk);
        m_update(i_rd, i_wr, i_a, i_d, i_rdy);
    endtask

    initial begin
        int          sel;
        logic [14:0] ra;

        for (int i = 0; i < RAM_SIZE; i++) begin
            m_ram[i]       = 8'($urandom);
            dut.r_mem[i]   = m_ram[i];
        end

        // Reset state
        #1;
        check("rst_con_valid", {7'd0, con_valid}, 8'h00);
        check("rst_con_data", con_data, 8'h00);
        check("rst_err", err_count, 8'h00);
        check("rst_no_strobe", rdata, 8'h00);
        rd = 1'b1; addr = IO + 15'd1;
        #1;
        check("rst_stat", rdata, 8'h01);
        rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // RAM write then read
        step(0, 1, 15'h10, 8'hA5, 0);
        step(1, 0, 15'h10, 8'h00, 0);
        check("ram_a5", obs_rd, 8'hA5);
        step(0, 0, 15'h10, 8'h00, 0);
        check("ram_no_strobe", obs_rd, 8'h00);

        // Error counter: count, saturate, clear
        repeat (3) step(1, 0, 15'h1234, 8'h00, 0);
        step(0, 0, 15'h0, 8'h00, 0);
        check("err_three", obs_err, 8'd3);
        repeat (300) step(1, 0, 15'h1234, 8'h00, 0);
        step(0, 0, 15'h0, 8'h00, 0);
        check("err_sat", obs_err, 8'hFF);
        step(0, 1, IO + 15'd2, 8'h5A, 0);
        step(0, 0, 15'h0, 8'h00, 0);
        check("err_clear", obs_err, 8'h00);

`ifdef MISAO_MEM_CONSOLE_EN
        // Fill past full, then drain
        for (int i = 0; i < 5; i++) step(0, 1, IO, 8'h41 + 8'(i), 0);
        step(1, 0, IO + 15'd1, 8'h00, 0);
        check("stat_full_ovf", obs_rd, 8'h26);
        step(0, 1, IO + 15'd1, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 15'h0, 8'h00, 1);
            check("drain_byte", obs_cd, 8'h41 + 8'(i));
        end
        step(0, 0, 15'h0, 8'h00, 1);
        check("drained_empty", {7'd0, obs_cv}, 8'h00);

        // Push into a full FIFO with a same-cycle pop
        for (int i = 0; i < 4; i++) step(0, 1, IO, 8'h61 + 8'(i), 0);
        step(0, 1, IO, 8'h55, 1);
        step(1, 0, IO + 15'd1, 8'h00, 0);
        check("stat_push_pop", obs_rd, 8'h22);
        check("head_push_pop", obs_cd, 8'h62);
        repeat (4) step(0, 0, 15'h0, 8'h00, 1);
`else
        // Console absent: CON_DATA writes vanish without counting as errors
        step(0, 1, IO, 8'h41, 1);
        step(1, 0, IO + 15'd1, 8'h00, 1);
        check("stat_disabled", obs_rd, 8'h01);
        check("con_write_not_err", obs_err, 8'h00);
        check("con_valid_disabled", {7'd0, obs_cv}, 8'h00);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)       ra = 15'($urandom_range(0, 255));
            else if (sel < 8)  ra = IO + 15'($urandom_range(0, 3));
            else if (sel == 8) ra = 15'($urandom_range(256, 32751));
            else               ra = 15'($urandom_range(32756, 32767));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a drain
        step(0, 1, 15'h10, 8'hA5, 0);
        step(0, 1, IO, 8'h71, 0);
        step(0, 1, IO, 8'h72, 0);
        step(1, 0, 15'h1234, 8'h00, 1);
        step(0, 0, 15'h0, 8'h00, 0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_con_valid", {7'd0, con_valid}, 8'h00);
        check("mid_rst_con_data", con_data, 8'h00);
        check("mid_rst_err", err_count, 8'h00);
        rd = 1'b1; addr = IO + 15'd1;
        #1;
        check("mid_rst_stat", rdata, 8'h01);
        addr = 15'h10;
        #1;
        check("mid_rst_ram", rdata, 8'hA5);
        rd = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        m_err = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 15'h10, 8'h00, 0);
        check("ram_kept", obs_rd, 8'hA5);
        step(0, 0, 15'h0, 8'h00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
